// File: rtl/cache_pkg.sv
// Shared types and geometry for the 2-way set-associative data cache.
package cache_pkg;

  localparam int unsigned TAG_W   = 11;
  localparam int unsigned INDEX_W = 6;
  localparam int unsigned ADDR_W  = TAG_W + INDEX_W + 1;
  localparam int unsigned SETS    = 1 << INDEX_W;

  typedef struct packed {
    logic [63:0]      data;
    logic [TAG_W-1:0] tag;
    logic             valid;
  } line_t;

  typedef enum logic [1:0] {
    IDLE,
    READ_MISS,
    WRITE
  } state_t;

endpackage

// File: rtl/cache_set_array.sv
// Two-way tag/data/valid storage plus per-set LRU bit; asynchronous read, synchronous writes.
module cache_set_array
  import cache_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [INDEX_W-1:0] i_index,
  output line_t [1:0]        o_lines,
  output logic               o_lru,
  input  logic [1:0]         i_line_we,
  input  logic [63:0]        i_line_data,
  input  logic [TAG_W-1:0]   i_line_tag,
  input  logic [1:0]         i_word_we,
  input  logic               i_word_off,
  input  logic [31:0]        i_word,
  input  logic               i_lru_we,
  input  logic               i_lru_val
);

  logic [SETS-1:0] r_lru;

  for (genvar w = 0; w < 2; w++) begin : g_way
    logic [63:0]      r_data [SETS];
    logic [TAG_W-1:0] r_tag  [SETS];
    logic [SETS-1:0]  r_valid;

    assign o_lines[w] = '{data: r_data[i_index], tag: r_tag[i_index], valid: r_valid[i_index]};

    // Data and tags are not reset; the valid bits alone gate hits.
    always_ff @(posedge i_clk) begin
      if (i_line_we[w]) begin
        r_data[i_index] <= i_line_data;
        r_tag[i_index]  <= i_line_tag;
      end else if (i_word_we[w]) begin
        if (i_word_off) r_data[i_index][63:32] <= i_word;
        else            r_data[i_index][31:0]  <= i_word;
      end
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_valid <= '0;
      end else if (i_line_we[w]) begin
        r_valid[i_index] <= 1'b1;
      end
    end
  end

  assign o_lru = r_lru[i_index];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lru <= '0;
    end else if (i_lru_we) begin
      r_lru[i_index] <= i_lru_val;
    end
  end

endmodule

// File: rtl/cache_controller.sv
// Write-through, no-write-allocate 2-way data cache sequencer between MEM stage and SRAM.
// Optional hit/miss counters are enabled by defining CACHE_STATS_EN.
module cache_controller
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              sram_r_en,
  output logic              sram_w_en,
  output logic [ADDR_W-1:0] sram_address,
  output logic [31:0]       sram_wdata,
  input  logic [63:0]       sram_rdata,
  input  logic              sram_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  state_t            r_state;
  logic              r_sram_r_en;
  logic              r_sram_w_en;
  logic [ADDR_W-1:0] r_sram_address;
  logic [31:0]       r_sram_wdata;

  logic [TAG_W-1:0]   w_tag;
  logic [INDEX_W-1:0] w_index;
  logic               w_off;
  line_t [1:0]        w_lines;
  logic               w_lru;
  logic               w_hit0;
  logic               w_hit1;
  logic               w_hit;
  logic [63:0]        w_hit_line;
  logic               w_victim;
  logic               w_idle;
  logic               w_fill;
  logic               w_rd_hit;
  logic               w_wr_hit;
  logic [1:0]         w_line_we;
  logic [1:0]         w_word_we;
  logic               w_lru_we;
  logic               w_lru_val;

  assign w_tag   = address[ADDR_W-1 -: TAG_W];
  assign w_index = address[INDEX_W:1];
  assign w_off   = address[0];

  assign w_hit0     = w_lines[0].valid && (w_lines[0].tag == w_tag);
  assign w_hit1     = w_lines[1].valid && (w_lines[1].tag == w_tag);
  assign w_hit      = w_hit0 | w_hit1;
  assign w_hit_line = w_hit1 ? w_lines[1].data : w_lines[0].data;

  // Fill empty ways first (way0 before way1), otherwise replace the LRU way.
  assign w_victim = !w_lines[0].valid ? 1'b0 :
                    !w_lines[1].valid ? 1'b1 : w_lru;

  assign w_idle   = (r_state == IDLE);
  assign w_fill   = (r_state == READ_MISS) && sram_ready;
  assign w_rd_hit = w_idle && mem_r_en && !mem_w_en && w_hit;
  assign w_wr_hit = w_idle && mem_w_en && w_hit;

  assign w_line_we = w_fill ? (w_victim ? 2'b10 : 2'b01) : 2'b00;
  assign w_word_we = (w_idle && mem_w_en) ? {w_hit1, w_hit0} : 2'b00;
  assign w_lru_we  = w_fill | w_rd_hit | w_wr_hit;
  assign w_lru_val = w_fill ? ~w_victim : ~w_hit1;

  cache_set_array u_set_array (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_index     (w_index),
    .o_lines     (w_lines),
    .o_lru       (w_lru),
    .i_line_we   (w_line_we),
    .i_line_data (sram_rdata),
    .i_line_tag  (w_tag),
    .i_word_we   (w_word_we),
    .i_word_off  (w_off),
    .i_word      (wdata),
    .i_lru_we    (w_lru_we),
    .i_lru_val   (w_lru_val)
  );

  always_comb begin
    ready = 1'b1;
    rdata = '0;
    unique case (r_state)
      IDLE: begin
        if (mem_w_en) begin
          ready = 1'b0;
        end else if (mem_r_en) begin
          ready = w_hit;
          if (w_hit) rdata = w_off ? w_hit_line[63:32] : w_hit_line[31:0];
        end
      end
      READ_MISS: begin
        ready = sram_ready;
        if (sram_ready) rdata = w_off ? sram_rdata[63:32] : sram_rdata[31:0];
      end
      WRITE: ready = sram_ready;
      default: ready = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_sram_r_en    <= 1'b0;
      r_sram_w_en    <= 1'b0;
      r_sram_address <= '0;
      r_sram_wdata   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          // Writes win over simultaneous reads.
          if (mem_w_en) begin
            r_state        <= WRITE;
            r_sram_w_en    <= 1'b1;
            r_sram_address <= address;
            r_sram_wdata   <= wdata;
          end else if (mem_r_en && !w_hit) begin
            r_state        <= READ_MISS;
            r_sram_r_en    <= 1'b1;
            r_sram_address <= {w_tag, w_index, 1'b0};
          end
        end
        READ_MISS: begin
          if (sram_ready) begin
            r_state     <= IDLE;
            r_sram_r_en <= 1'b0;
          end
        end
        WRITE: begin
          if (sram_ready) begin
            r_state     <= IDLE;
            r_sram_w_en <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sram_r_en    = r_sram_r_en;
  assign sram_w_en    = r_sram_w_en;
  assign sram_address = r_sram_address;
  assign sram_wdata   = r_sram_wdata;

`ifdef CACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_rd_hit && (r_hit_count != 32'hFFFF_FFFF)) r_hit_count <= r_hit_count + 32'd1;
      if (w_fill && (r_miss_count != 32'hFFFF_FFFF)) r_miss_count <= r_miss_count + 32'd1;
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: vector table with a scoreboard plus corner sequences.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [17:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        sram_r_en;
  logic        sram_w_en;
  logic [17:0] sram_address;
  logic [31:0] sram_wdata;
  logic [63:0] sram_rdata;
  logic        sram_ready;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  always #5 clk = ~clk;

  cache_controller dut (
    .clk          (clk),
    .rst          (rst),
    .mem_r_en     (mem_r_en),
    .mem_w_en     (mem_w_en),
    .address      (address),
    .wdata        (wdata),
    .rdata        (rdata),
    .ready        (ready),
    .sram_r_en    (sram_r_en),
    .sram_w_en    (sram_w_en),
    .sram_address (sram_address),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata),
    .sram_ready   (sram_ready)
`ifdef CACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  typedef struct {
    bit          rd;
    bit          wr;
    logic [17:0] addr;
    logic [31:0] wd;
    logic [63:0] line;
    bit          acc;
    logic [17:0] saddr;
    logic [31:0] rdat;
  } vec_t;

  typedef struct {
    bit          acc;
    bit          wr;
    logic [17:0] saddr;
    logic [31:0] swdata;
    logic [31:0] rdat;
    bit          chk_rdata;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[19];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drives one request, plays the SRAM side when the DUT asks for it, then scores the outcome.
  task automatic run_req(input vec_t v, input string name);
    exp_t        e;
    bit          got_acc;
    bit          got_wr;
    logic [17:0] got_saddr;
    logic [31:0] got_swdata;
    logic [31:0] got_rdata;
    logic        got_ready;
    int          n;
    e = '{acc: v.acc, wr: v.wr, saddr: v.saddr, swdata: v.wd, rdat: v.rdat, chk_rdata: !v.wr};
    got_wr     = 1'b0;
    got_saddr  = '0;
    got_swdata = '0;
    @(negedge clk);
    mem_r_en = v.rd;
    mem_w_en = v.wr;
    address  = v.addr;
    wdata    = v.wd;
    sb.push_back(e);
    #1;
    if (ready) begin
      got_acc   = 1'b0;
      got_rdata = rdata;
      @(posedge clk);
      #1;
      check({name, "_no_sram"}, {62'b0, sram_r_en, sram_w_en}, 64'd0);
    end else begin
      got_acc = 1'b1;
      @(posedge clk);
      #1;
      n = 0;
      while (!(sram_r_en || sram_w_en) && n < 10) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (n == 10) check({name, "_sram_req_timeout"}, 64'd0, 64'd1);
      got_wr     = sram_w_en;
      got_saddr  = sram_address;
      got_swdata = sram_wdata;
      check({name, "_pending_ready"}, {63'b0, ready}, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      check({name, "_en_held"}, {63'b0, sram_r_en | sram_w_en}, 64'd1);
      @(negedge clk);
      sram_rdata = v.line;
      sram_ready = 1'b1;
      #1;
      got_ready = ready;
      got_rdata = rdata;
      @(posedge clk);
      #1;
      sram_ready = 1'b0;
      check({name, "_ready_on_done"}, {63'b0, got_ready}, 64'd1);
      check({name, "_en_dropped"}, {62'b0, sram_r_en, sram_w_en}, 64'd0);
    end
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    e = sb.pop_front();
    check({name, "_access"}, {63'b0, got_acc}, {63'b0, e.acc});
    if (e.acc) begin
      check({name, "_kind"}, {63'b0, got_wr}, {63'b0, e.wr});
      check({name, "_saddr"}, {46'b0, got_saddr}, {46'b0, e.saddr});
      if (e.wr) check({name, "_swdata"}, {32'b0, got_swdata}, {32'b0, e.swdata});
    end
    if (e.chk_rdata) check({name, "_rdata"}, {32'b0, got_rdata}, {32'b0, e.rdat});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //          rd wr addr       wdata         fill line               acc saddr      rdata
    vecs[0]  = '{1, 0, 18'h00010, 32'h0,        64'hBBBBBBBB_AAAAAAAA, 1, 18'h00010, 32'hAAAAAAAA};
    vecs[1]  = '{1, 0, 18'h00010, 32'h0,        64'h0,                 0, 18'h0,     32'hAAAAAAAA};
    vecs[2]  = '{1, 0, 18'h00011, 32'h0,        64'h0,                 0, 18'h0,     32'hBBBBBBBB};
    vecs[3]  = '{1, 0, 18'h0008A, 32'h0,        64'h0000_0000_11111111, 1, 18'h0008A, 32'h11111111};
    vecs[4]  = '{1, 0, 18'h0010A, 32'h0,        64'h0000_0000_22222222, 1, 18'h0010A, 32'h22222222};
    vecs[5]  = '{1, 0, 18'h0008A, 32'h0,        64'h0,                 0, 18'h0,     32'h11111111};
    vecs[6]  = '{1, 0, 18'h0018A, 32'h0,        64'h0000_0000_33333333, 1, 18'h0018A, 32'h33333333};
    vecs[7]  = '{1, 0, 18'h0008A, 32'h0,        64'h0,                 0, 18'h0,     32'h11111111};
    vecs[8]  = '{1, 0, 18'h0010A, 32'h0,        64'h0000_0000_22222222, 1, 18'h0010A, 32'h22222222};
    vecs[9]  = '{1, 0, 18'h0008A, 32'h0,        64'h0,                 0, 18'h0,     32'h11111111};
    vecs[10] = '{1, 0, 18'h0018A, 32'h0,        64'h0000_0000_33333333, 1, 18'h0018A, 32'h33333333};
    vecs[11] = '{0, 1, 18'h00010, 32'h12345678, 64'h0,                 1, 18'h00010, 32'h0};
    vecs[12] = '{1, 0, 18'h00010, 32'h0,        64'h0,                 0, 18'h0,     32'h12345678};
    vecs[13] = '{1, 0, 18'h00011, 32'h0,        64'h0,                 0, 18'h0,     32'hBBBBBBBB};
    vecs[14] = '{0, 1, 18'h3FF00, 32'hCAFEF00D, 64'h0,                 1, 18'h3FF00, 32'h0};
    vecs[15] = '{1, 0, 18'h3FF00, 32'h0,        64'h55555555_66666666, 1, 18'h3FF00, 32'h66666666};
    vecs[16] = '{1, 1, 18'h00011, 32'h0BADCAFE, 64'h0,                 1, 18'h00011, 32'h0};
    vecs[17] = '{1, 0, 18'h00011, 32'h0,        64'h0,                 0, 18'h0,     32'h0BADCAFE};
    vecs[18] = '{1, 0, 18'h00010, 32'h0,        64'h0,                 0, 18'h0,     32'h12345678};

    rst        = 1'b1;
    mem_r_en   = 1'b0;
    mem_w_en   = 1'b0;
    address    = '0;
    wdata      = '0;
    sram_rdata = '0;
    sram_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_ready", {63'b0, ready}, 64'd1);
    check("reset_rdata", {32'b0, rdata}, 64'd0);
    check("reset_sram_en", {62'b0, sram_r_en, sram_w_en}, 64'd0);

    for (int i = 0; i < 19; i++) run_req(vecs[i], $sformatf("v%0d", i));

    // A stray sram_ready while idle must not disturb anything.
    @(negedge clk);
    sram_ready = 1'b1;
    #1;
    check("idle_pulse_ready", {63'b0, ready}, 64'd1);
    @(posedge clk);
    #1;
    sram_ready = 1'b0;
    check("idle_pulse_sram_en", {62'b0, sram_r_en, sram_w_en}, 64'd0);
    run_req(vecs[18], "idle_pulse_then_hit");

    // Reset while a line fill is outstanding.
    @(negedge clk);
    mem_r_en = 1'b1;
    address  = 18'h20000;
    @(posedge clk);
    #1;
    check("rstmid_in_miss", {63'b0, sram_r_en}, 64'd1);
    @(negedge clk);
    rst      = 1'b1;
    mem_r_en = 1'b0;
    @(posedge clk);
    #1;
    check("rstmid_sram_en", {62'b0, sram_r_en, sram_w_en}, 64'd0);
    check("rstmid_ready", {63'b0, ready}, 64'd1);
`ifdef CACHE_STATS_EN
    check("rstmid_hit_count", {32'b0, hit_count}, 64'd0);
    check("rstmid_miss_count", {32'b0, miss_count}, 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    v   = '{1, 0, 18'h00010, 32'h0, 64'hBBBBBBBB_AAAAAAAA, 1, 18'h00010, 32'hAAAAAAAA};
    run_req(v, "post_rst_miss");
    v   = '{1, 0, 18'h0008A, 32'h0, 64'h0000_0000_77777777, 1, 18'h0008A, 32'h77777777};
    run_req(v, "post_rst_miss2");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
